// File: rtl/mas_pkg.sv
// Shared opcodes, FSM states and correction-compare codes for the streaming
// modular accumulator.
package mas_pkg;

  localparam logic [1:0] SEL_LOAD = 2'b00;
  localparam logic [1:0] SEL_ADD  = 2'b01;
  localparam logic [1:0] SEL_SUB  = 2'b10;
  localparam logic [1:0] SEL_HOLD = 2'b11;

  localparam logic [1:0] CMP_IN  = 2'b00;
  localparam logic [1:0] CMP_HI  = 2'b01;
  localparam logic [1:0] CMP_NEG = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ACC  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/mas_modcorr.sv
// Combinational single-step modular correction of a signed raw sum into
// [0, q-1], with a code telling which correction was taken.
module mas_modcorr
  import mas_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic signed [DW+1:0] raw,
  input  logic        [DW-1:0] q,
  output logic        [DW-1:0] residue,
  output logic        [1:0]    cmp
);

  logic signed [DW+1:0] q_x;
  logic signed [DW+1:0] zero_x;

  // The corrected value always lies in [0, 2^DW), so the low DW bits of the
  // raw value carry everything needed for the modular add/subtract.
  always_comb begin
    q_x     = $signed({2'b00, q});
    zero_x  = '0;
    residue = raw[DW-1:0];
    cmp     = CMP_IN;
    if (raw >= q_x) begin
      residue = raw[DW-1:0] - q;
      cmp     = CMP_HI;
    end else if (raw < zero_x) begin
      residue = raw[DW-1:0] + q;
      cmp     = CMP_NEG;
    end
  end

endmodule

// File: rtl/mas_stream_acc.sv
// Streaming modular accumulator: folds a frame of operands under per-beat
// opcodes into a residue mod Q. Optional trace outputs under MAS_TRACE_EN.
module mas_stream_acc
  import mas_pkg::*;
#(
  parameter int DW = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_sel,
  input  logic [DW-1:0] in_din,
  input  logic [DW-1:0] in_q,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] dout,
  output logic [CW-1:0] out_cnt,
  output logic          out_err
`ifdef MAS_TRACE_EN
  ,
  output logic signed [DW+1:0] tdout,
  output logic        [1:0]    tcmp
`endif
);

  state_t state_q, state_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] q_q, q_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [DW-1:0] dout_q, dout_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic          out_err_q, out_err_d;

  logic                 accept;
  logic                 first;
  logic [DW-1:0]        q_eff;
  logic [DW-1:0]        acc_eff;
  logic signed [DW+1:0] acc_x;
  logic signed [DW+1:0] din_x;
  logic signed [DW+1:0] raw;
  logic [DW-1:0]        residue;
  logic                 q_bad;
  logic                 din_err;

  assign in_ready  = (state_q != ST_DONE);
  assign out_valid = (state_q == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign first     = (state_q == ST_IDLE);

  // The first beat of a frame sees the live modulus and an empty accumulator.
  always_comb begin
    q_eff   = first ? in_q : q_q;
    acc_eff = first ? '0 : acc_q;
    acc_x   = $signed({2'b00, acc_eff});
    din_x   = $signed({2'b00, in_din});
    q_bad   = (q_eff < DW'(2));
    din_err = (in_sel != SEL_HOLD) && (in_din >= q_eff);
    case (in_sel)
      SEL_LOAD: raw = din_x;
      SEL_ADD:  raw = acc_x + din_x;
      SEL_SUB:  raw = acc_x - din_x;
      default:  raw = acc_x;
    endcase
  end

`ifdef MAS_TRACE_EN
  logic [1:0] cmp;

  mas_modcorr #(.DW(DW)) u_corr (
    .raw     (raw),
    .q       (q_eff),
    .residue (residue),
    .cmp     (cmp)
  );
`else
  mas_modcorr #(.DW(DW)) u_corr (
    .raw     (raw),
    .q       (q_eff),
    .residue (residue),
    .cmp     ()
  );
`endif

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    dout_d    = dout_q;
    out_cnt_d = out_cnt_q;
    out_err_d = out_err_q;
    case (state_q)
      ST_IDLE, ST_ACC: begin
        if (accept) begin
          q_d   = q_eff;
          acc_d = residue;
          if (first) begin
            cnt_d = CW'(1);
            err_d = q_bad | din_err;
          end else begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
            err_d = err_q | q_bad | din_err;
          end
          if (in_last) begin
            state_d   = ST_DONE;
            dout_d    = q_bad ? '0 : residue;
            out_cnt_d = cnt_d;
            out_err_d = err_d;
          end else begin
            state_d = ST_ACC;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      dout_q    <= '0;
      out_cnt_q <= '0;
      out_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      dout_q    <= dout_d;
      out_cnt_q <= out_cnt_d;
      out_err_q <= out_err_d;
    end
  end

  assign dout    = dout_q;
  assign out_cnt = out_cnt_q;
  assign out_err = out_err_q;

`ifdef MAS_TRACE_EN
  logic signed [DW+1:0] tdout_q, tdout_d;
  logic        [1:0]    tcmp_q, tcmp_d;

  always_comb begin
    tdout_d = tdout_q;
    tcmp_d  = tcmp_q;
    if (accept) begin
      tdout_d = raw;
      tcmp_d  = cmp;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tdout_q <= '0;
      tcmp_q  <= '0;
    end else begin
      tdout_q <= tdout_d;
      tcmp_q  <= tcmp_d;
    end
  end

  assign tdout = tdout_q;
  assign tcmp  = tcmp_q;
`endif

endmodule

// File: tb/tb_mas_stream_acc.sv
// Scoreboard bench for mas_stream_acc: directed frames push expected results,
// a negedge monitor pops them on each output handshake.
module tb_mas_stream_acc;
  localparam int DW = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_sel = 2'b00;
  logic [DW-1:0] in_din = '0;
  logic [DW-1:0] in_q = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] dout;
  logic [CW-1:0] out_cnt;
  logic          out_err;
`ifdef MAS_TRACE_EN
  logic signed [DW+1:0] tdout;
  logic        [1:0]    tcmp;
`endif

  mas_stream_acc #(.DW(DW), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_din    (in_din),
    .in_q      (in_q),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .out_cnt   (out_cnt),
    .out_err   (out_err)
`ifdef MAS_TRACE_EN
    ,
    .tdout     (tdout),
    .tcmp      (tcmp)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    dout;
    int    cnt;
    int    err;
    bit    chk_dout;
  } exp_t;

  exp_t q_exp[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic expect_res(input string nm, input int d, input int c, input int e, input bit cd);
    exp_t x;
    x.name = nm;
    x.dout = d;
    x.cnt = c;
    x.err = e;
    x.chk_dout = cd;
    q_exp.push_back(x);
  endtask

  // Called at posedge+1; returns at posedge+1 right after the acceptance edge.
  task automatic beat(input logic [1:0] sel, input int din, input int q, input bit last,
                      output int waits);
    bit ok;
    ok = 1'b0;
    waits = 0;
    in_valid = 1'b1;
    in_sel = sel;
    in_din = din[DW-1:0];
    in_q = q[DW-1:0];
    in_last = last;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else begin
        waits++;
        @(posedge clk);
        #1;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: got in_ready=0 for 50 cycles expected acceptance");
    end else begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    $display("beat sel=%0d din=%0d q=%0d last=%0d waits=%0d", sel, din, q, last, waits);
  endtask

  task automatic drain;
    for (int i = 0; i < 100 && q_exp.size() > 0; i++) @(posedge clk);
    #1;
    if (q_exp.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", q_exp.size());
      q_exp.delete();
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (q_exp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got dout=%0d expected no result", dout);
      end else begin
        e = q_exp.pop_front();
        $display("result %s dout=%0d cnt=%0d err=%0d", e.name, dout, out_cnt, out_err);
        if (e.chk_dout) chk({e.name, "_dout"}, int'(dout), e.dout);
        chk({e.name, "_cnt"}, int'(out_cnt), e.cnt);
        chk({e.name, "_err"}, int'(out_err), e.err);
      end
    end
  end

  initial begin
    int w;
    #12;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_dout", int'(dout), 0);
    chk("reset_out_cnt", int'(out_cnt), 0);
    chk("reset_out_err", int'(out_err), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_in_ready", int'(in_ready), 1);

    // Q=7: 5, +4 -> 2, +6 -> 1
    expect_res("f1", 1, 3, 0, 1'b1);
    beat(SEL_LOAD_C(), 5, 7, 1'b0, w);
    beat(2'b01, 4, 7, 1'b0, w);
    chk("f1_valid_before_last", int'(out_valid), 0);
    beat(2'b01, 6, 7, 1'b1, w);
    chk("f1_latency", int'(out_valid), 1);
    drain();

    // Q=11: 3 - 7 = -4 -> 7
    expect_res("f2", 7, 2, 0, 1'b1);
    beat(2'b00, 3, 11, 1'b0, w);
    beat(2'b10, 7, 11, 1'b1, w);
`ifdef MAS_TRACE_EN
    chk("f2_tdout", int'(tdout), -4);
    chk("f2_tcmp", int'(tcmp), 2);
`endif
    drain();

    // Q=13, result held under backpressure, then the mandatory bubble
    out_ready = 1'b0;
    expect_res("f3", 12, 3, 0, 1'b1);
    beat(2'b00, 12, 13, 1'b0, w);
    beat(2'b11, 9, 13, 1'b0, w);
    beat(2'b01, 0, 13, 1'b1, w);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("f3_hold_in_ready", int'(in_ready), 0);
      chk("f3_hold_valid", int'(out_valid), 1);
      chk("f3_hold_dout", int'(dout), 12);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("f3_bubble_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    chk("f3_released_valid", int'(out_valid), 0);
    chk("f3_kept_dout", int'(dout), 12);
    expect_res("f3b", 1, 1, 0, 1'b1);
    beat(2'b00, 1, 13, 1'b1, w);
    chk("f3_after_bubble_waits", w, 0);
    drain();

    // Q=5: operand 6 out of range flags error; next frame is clean
    expect_res("f4", 0, 2, 1, 1'b0);
    beat(2'b00, 2, 5, 1'b0, w);
    beat(2'b01, 6, 5, 1'b1, w);
    drain();
    expect_res("f4b", 4, 2, 0, 1'b1);
    beat(2'b00, 1, 5, 1'b0, w);
    beat(2'b01, 3, 5, 1'b1, w);
    drain();

    // Q=9: reset mid-frame discards everything asynchronously
    beat(2'b00, 4, 9, 1'b0, w);
    beat(2'b01, 3, 9, 1'b0, w);
    rst = 1'b1;
    #1;
    chk("f5_rst_out_valid", int'(out_valid), 0);
    chk("f5_rst_dout", int'(dout), 0);
    chk("f5_rst_out_cnt", int'(out_cnt), 0);
    chk("f5_rst_out_err", int'(out_err), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    expect_res("f5", 8, 1, 0, 1'b1);
    beat(2'b00, 8, 9, 1'b1, w);
    drain();

    // Degenerate moduli force dout to 0 and flag an error
    expect_res("f6", 0, 1, 1, 1'b1);
    beat(2'b00, 0, 1, 1'b1, w);
    drain();
    expect_res("f7", 0, 1, 1, 1'b1);
    beat(2'b00, 3, 0, 1'b1, w);
    drain();

    // Beat counter saturation at 255 over a 300-beat frame; in_q changes ignored
    expect_res("f8", 1, 255, 0, 1'b1);
    beat(2'b00, 1, 3, 1'b0, w);
    for (int i = 0; i < 298; i++) beat(2'b11, 0, 15, 1'b0, w);
    beat(2'b11, 0, 15, 1'b1, w);
    drain();

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  function automatic logic [1:0] SEL_LOAD_C();
    return 2'b00;
  endfunction

endmodule
